// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer
//   Tile controller for the systolic array. One start request runs one tile:
//   pop a weight set from the weight FIFO, pulse the array weight reload,
//   stream cfg_len activation vectors out of the unified buffer with per-lane
//   skew, de-skew the array results, requantise them and write them back.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   start              one-cycle tile request (ignored unless idle)
//   cfg_in_base        first activation address
//   cfg_out_base       first result address
//   cfg_len            number of vectors (0 gives an empty tile)
//   cfg_shift          arithmetic right shift for requantisation
//   cfg_relu           clamp negative results to zero
//   busy, done         tile in progress / one-cycle end-of-tile pulse
//   fifo_empty         weight FIFO empty
//   fifo_rd_en         weight FIFO pop
//   we_rl              weight reload pulse to the array
//   ub_rd_en/addr/data UB read port (data valid one cycle after the strobe)
//   din_skew           skewed activations to the array
//   array_result       raw array outputs (lane j lags lane 0 by j cycles)
//   ub_wr_en/addr/data UB write port carrying requantised results
module tpu_tile_sequencer #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int DATA_BW   = 8,
  parameter int PSUM_BW   = 20,
  parameter int ADDR_W    = 10,
  parameter int ARRAY_LAT = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_in_base,
  input  logic [ADDR_W-1:0]         cfg_out_base,
  input  logic [ADDR_W-1:0]         cfg_len,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  output logic                      busy,
  output logic                      done,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  output logic                      we_rl,
  output logic                      ub_rd_en,
  output logic [ADDR_W-1:0]         ub_rd_addr,
  input  logic [COLS*DATA_BW-1:0]   ub_rd_data,
  output logic [COLS*DATA_BW-1:0]   din_skew,
  input  logic [ROWS*PSUM_BW-1:0]   array_result,
  output logic                      ub_wr_en,
  output logic [ADDR_W-1:0]         ub_wr_addr,
  output logic [ROWS*DATA_BW-1:0]   ub_wr_data
);

  // One bit per cycle from read strobe to write strobe; the last bit is ub_wr_en.
  localparam int VLD_N = 1 + ARRAY_LAT + ROWS;
  localparam logic signed [PSUM_BW-1:0] SAT_MAX = PSUM_BW'(2**(DATA_BW-1) - 1);
  localparam logic signed [PSUM_BW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_WPOP, S_WLOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [ADDR_W-1:0]      r_in_base, r_out_base, r_len, r_cnt, r_wr_cnt, r_wr_addr;
  logic [4:0]             r_shift;
  logic                   r_relu, r_busy, r_done;
  logic [VLD_N-1:0]       r_vld;
  logic [ROWS*DATA_BW-1:0] r_wr_data;
  logic [COLS*DATA_BW-1:0] w_act_p0;
  logic [ROWS*PSUM_BW-1:0] w_dsk_p1;

  function automatic logic signed [DATA_BW-1:0] sat(input logic signed [PSUM_BW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_BW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_BW-1:0];
    else                  return v[DATA_BW-1:0];
  endfunction

  function automatic logic signed [DATA_BW-1:0] requant(input logic signed [PSUM_BW-1:0] psum,
                                                        input logic [4:0] sh, input logic relu);
    logic signed [PSUM_BW-1:0] r;
    r = psum >>> sh;
    if (relu && r[PSUM_BW-1]) r = '0;
    return sat(r);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (cfg_len == '0) ? S_DONE : S_WPOP;
      S_WPOP:   if (!fifo_empty) w_next = S_WLOAD;
      S_WLOAD:  w_next = S_STREAM;
      S_STREAM: if (r_cnt == r_len - ADDR_W'(1)) w_next = S_DRAIN;
      // Leave once the final result is entering the write stage and nothing
      // is behind it; DONE then coincides with the last write strobe.
      S_DRAIN:  if (r_vld[VLD_N-3:0] == '0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    we_rl      = 1'b0;
    ub_rd_en   = 1'b0;
    ub_rd_addr = '0;
    case (r_state)
      S_WPOP:   fifo_rd_en = !fifo_empty;
      S_WLOAD:  we_rl = 1'b1;
      S_STREAM: begin
        ub_rd_en   = 1'b1;
        ub_rd_addr = r_in_base + r_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_wr_cnt   <= '0;
      r_vld      <= '0;
      r_in_base  <= '0;
      r_out_base <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      r_vld  <= {r_vld[VLD_N-2:0], ub_rd_en};
      if (r_state == S_IDLE && start) begin
        r_in_base  <= cfg_in_base;
        r_out_base <= cfg_out_base;
        r_len      <= cfg_len;
        r_shift    <= cfg_shift;
        r_relu     <= cfg_relu;
        r_busy     <= 1'b1;
        r_cnt      <= '0;
        r_wr_cnt   <= '0;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
      if (r_state == S_STREAM) r_cnt <= r_cnt + ADDR_W'(1);
      if (r_vld[VLD_N-2])      r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
    end
  end

  // p0: UB read data, forced to zero when no vector is in this slot
  assign w_act_p0 = r_vld[0] ? ub_rd_data : '0;

  genvar gi;
  for (gi = 0; gi < COLS; gi++) begin : g_skew
    if (gi == 0) begin : g_pass
      assign din_skew[DATA_BW-1:0] = w_act_p0[DATA_BW-1:0];
    end else begin : g_dly
      logic [DATA_BW-1:0] r_skew_p [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) r_skew_p[k] <= '0;
        end else begin
          r_skew_p[0] <= w_act_p0[gi*DATA_BW +: DATA_BW];
          for (int k = 1; k < gi; k++) r_skew_p[k] <= r_skew_p[k-1];
        end
      end
      assign din_skew[gi*DATA_BW +: DATA_BW] = r_skew_p[gi-1];
    end
  end

  // p1: array outputs re-aligned so all lanes of one vector appear together
  for (gi = 0; gi < ROWS; gi++) begin : g_dsk
    if (gi == ROWS - 1) begin : g_pass
      assign w_dsk_p1[gi*PSUM_BW +: PSUM_BW] = array_result[gi*PSUM_BW +: PSUM_BW];
    end else begin : g_dly
      localparam int D = ROWS - 1 - gi;
      logic [PSUM_BW-1:0] r_dsk_p [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) r_dsk_p[k] <= '0;
        end else begin
          r_dsk_p[0] <= array_result[gi*PSUM_BW +: PSUM_BW];
          for (int k = 1; k < D; k++) r_dsk_p[k] <= r_dsk_p[k-1];
        end
      end
      assign w_dsk_p1[gi*PSUM_BW +: PSUM_BW] = r_dsk_p[D-1];
    end
  end

  // p2: requantised write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (r_vld[VLD_N-2]) begin
      r_wr_addr <= r_out_base + r_wr_cnt;
      for (int j = 0; j < ROWS; j++)
        r_wr_data[j*DATA_BW +: DATA_BW] <= requant($signed(w_dsk_p1[j*PSUM_BW +: PSUM_BW]),
                                                   r_shift, r_relu);
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign ub_wr_en   = r_vld[VLD_N-1];
  assign ub_wr_addr = r_wr_addr;
  assign ub_wr_data = r_wr_data;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Testbench for tpu_tile_sequencer: behavioural UB (1-cycle read latency),
// a systolic array stand-in that scales each lane by a common weight after
// ARRAY_LAT cycles, and directed tiles with hand-computed expectations.
module tb_tpu_tile_sequencer;
  localparam int ROWS = 8, COLS = 8, DATA_BW = 8, PSUM_BW = 20, ADDR_W = 10, ARRAY_LAT = 9;

  logic clk = 1'b0;
  logic rst, start, cfg_relu, busy, done, fifo_empty, fifo_rd_en, we_rl;
  logic ub_rd_en, ub_wr_en;
  logic [ADDR_W-1:0] cfg_in_base, cfg_out_base, cfg_len, ub_rd_addr, ub_wr_addr;
  logic [4:0] cfg_shift;
  logic [COLS*DATA_BW-1:0] ub_rd_data, din_skew;
  logic [ROWS*PSUM_BW-1:0] array_result;
  logic [ROWS*DATA_BW-1:0] ub_wr_data;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .DATA_BW(DATA_BW), .PSUM_BW(PSUM_BW),
                       .ADDR_W(ADDR_W), .ARRAY_LAT(ARRAY_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_base(cfg_in_base),
    .cfg_out_base(cfg_out_base), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .busy(busy), .done(done), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .we_rl(we_rl), .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .ub_rd_data(ub_rd_data), .din_skew(din_skew), .array_result(array_result),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data));

  // Array stand-in: lane j result = lane j activation * wgt, ARRAY_LAT cycles later.
  logic [COLS*DATA_BW-1:0] dl [ARRAY_LAT];
  int wgt = 1;
  always @(posedge clk) begin
    dl[0] <= din_skew;
    for (int k = 1; k < ARRAY_LAT; k++) dl[k] <= dl[k-1];
  end
  always_comb begin
    array_result = '0;
    for (int j = 0; j < ROWS; j++)
      array_result[j*PSUM_BW +: PSUM_BW] = PSUM_BW'(int'($signed(dl[ARRAY_LAT-1][j*DATA_BW +: DATA_BW])) * wgt);
  end

  logic [63:0] ub_mem [1024];
  int cyc = 0, s_cyc, t_pop, t_wl, t_rd, t_wr, t_done, t_bh, t_bl, n_pop, n_rd, n_wr, n_done;
  logic [ADDR_W-1:0] rd_q[$], wr_q[$];
  logic rd_pend = 1'b0;
  logic [ADDR_W-1:0] rd_pend_addr = '0;
  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int v0, v1, v2, v3, v4, v5, v6, v7);
    return {v7[7:0], v6[7:0], v5[7:0], v4[7:0], v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  task automatic adv();
    @(posedge clk); #1;
    cyc++;
    if (rd_pend) ub_rd_data = ub_mem[rd_pend_addr];
  endtask

  task automatic mon();
    #1;
    rd_pend = ub_rd_en; rd_pend_addr = ub_rd_addr;
    if (ub_rd_en) begin n_rd++; rd_q.push_back(ub_rd_addr); if (t_rd < 0) t_rd = cyc; end
    if (ub_wr_en) begin
      n_wr++; wr_q.push_back(ub_wr_addr); ub_mem[ub_wr_addr] = ub_wr_data;
      if (t_wr < 0) t_wr = cyc;
    end
    if (fifo_rd_en) begin n_pop++; if (t_pop < 0) t_pop = cyc; end
    if (we_rl && t_wl < 0) t_wl = cyc;
    if (done) begin n_done++; if (t_done < 0) t_done = cyc; end
    if (busy && t_bh < 0) t_bh = cyc;
    if (!busy && t_bh >= 0 && t_bl < 0) t_bl = cyc;
  endtask

  task automatic clr();
    t_pop = -1; t_wl = -1; t_rd = -1; t_wr = -1; t_done = -1; t_bh = -1; t_bl = -1;
    n_pop = 0; n_rd = 0; n_wr = 0; n_done = 0;
    rd_q.delete(); wr_q.delete();
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_ctl"}, {busy, done, fifo_rd_en, we_rl, ub_rd_en, ub_wr_en}, 0);
    chk({pfx, "_addr"}, {ub_rd_addr, ub_wr_addr}, 0);
    chk({pfx, "_wdata"}, ub_wr_data, 0);
    chk({pfx, "_skew"}, din_skew, 0);
  endtask

  task automatic run_tile(input logic [ADDR_W-1:0] ib, ob, len, input logic [4:0] sh,
                          input logic rl, input int stall, input bit second);
    clr();
    cfg_in_base = ib; cfg_out_base = ob; cfg_len = len; cfg_shift = sh; cfg_relu = rl;
    fifo_empty = (stall > 0); start = 1'b1; s_cyc = cyc;
    for (int i = 1; i <= 300 && t_done < 0; i++) begin
      adv();
      start = second && (i == 4);
      if (start) begin cfg_len = 10'd7; cfg_out_base = 10'h200; end
      fifo_empty = (i <= stall);
      mon();
    end
    for (int i = 0; i < 6; i++) begin
      adv(); start = 1'b0; fifo_empty = 1'b0; mon();
    end
    chk("done_seen", t_done >= 0, 1);
  endtask

  logic [63:0] orig [4];

  initial begin
    rst = 1'b1; start = 1'b0; cfg_in_base = '0; cfg_out_base = '0; cfg_len = '0;
    cfg_shift = '0; cfg_relu = 1'b0; fifo_empty = 1'b0; ub_rd_data = '0;
    for (int a = 0; a < 1024; a++) ub_mem[a] = '0;
    clr();
    for (int i = 0; i < 3; i++) begin adv(); mon(); end
    chk_idle("por");
    rst = 1'b0;
    adv(); mon();

    // Identity weights, 4 vectors 0x010 -> 0x100
    wgt = 1;
    for (int k = 0; k < 4; k++) ub_mem[16+k] = 64'h0123_4567_89AB_CDEF + 64'h0101_0101_0101_0101 * k;
    run_tile(10'h010, 10'h100, 10'd4, 5'd0, 1'b0, 0, 1'b0);
    chk("id_pop", t_pop - s_cyc, 1);
    chk("id_wrl", t_wl - s_cyc, 2);
    chk("id_rd0", t_rd - s_cyc, 3);
    chk("id_wr0", t_wr - s_cyc, 21);
    chk("id_done", t_done - s_cyc, 25);
    chk("id_busy_rise", t_bh - s_cyc, 1);
    chk("id_busy_fall", t_bl - s_cyc, 25);
    chk("id_nwr", n_wr, 4);
    chk("id_npop", n_pop, 1);
    chk("id_wa0", wr_q.size() > 0 ? wr_q[0] : '1, 10'h100);
    for (int k = 0; k < 4; k++)
      chk($sformatf("id_data%0d", k), ub_mem[256+k], 64'h0123_4567_89AB_CDEF + 64'h0101_0101_0101_0101 * k);

    // FIFO empty for 5 cycles after start
    ub_mem[32] = 64'h1122_3344_5566_7788; ub_mem[33] = 64'h99AA_BBCC_DDEE_FF00;
    run_tile(10'h020, 10'h120, 10'd2, 5'd0, 1'b0, 5, 1'b0);
    chk("st_pop", t_pop - s_cyc, 6);
    chk("st_wrl", t_wl - s_cyc, 7);
    chk("st_rd0", t_rd - s_cyc, 8);
    chk("st_done", t_done - s_cyc, 28);
    chk("st_npop", n_pop, 1);
    chk("st_data1", ub_mem[10'h121], 64'h99AA_BBCC_DDEE_FF00);

    // Requantisation with weight 10
    wgt = 10;
    ub_mem[10'h030] = pk(100, -100, 20, -3, 0, 12, -128, 127);
    ub_mem[10'h031] = pk(-30, 5, -30, -30, -30, -30, -30, -30);
    run_tile(10'h030, 10'h130, 10'd1, 5'd2, 1'b0, 0, 1'b0);
    chk("rq_shift2", ub_mem[10'h130], pk(127, -128, 50, -8, 0, 30, -128, 127));
    run_tile(10'h031, 10'h131, 10'd1, 5'd0, 1'b1, 0, 1'b0);
    chk("rq_relu", ub_mem[10'h131], pk(0, 50, 0, 0, 0, 0, 0, 0));
    run_tile(10'h031, 10'h132, 10'd1, 5'd0, 1'b0, 0, 1'b0);
    chk("rq_satneg", ub_mem[10'h132], pk(-128, 50, -128, -128, -128, -128, -128, -128));

    // Address wrap on both ports
    wgt = 1;
    ub_mem[10'h3FE] = 64'hA0A1_A2A3_A4A5_A6A7; ub_mem[10'h3FF] = 64'hB0B1_B2B3_B4B5_B6B7;
    ub_mem[10'h000] = 64'h7071_7273_7475_7677; ub_mem[10'h001] = 64'h0F1E_2D3C_4B5A_6978;
    orig[0] = ub_mem[10'h3FE]; orig[1] = ub_mem[10'h3FF]; orig[2] = ub_mem[0]; orig[3] = ub_mem[1];
    run_tile(10'h3FE, 10'h3FF, 10'd4, 5'd0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_ra%0d", k), k < rd_q.size() ? rd_q[k] : '1, 10'(10'h3FE + k));
      chk($sformatf("wrap_wa%0d", k), k < wr_q.size() ? wr_q[k] : '1, 10'(10'h3FF + k));
      chk($sformatf("wrap_data%0d", k), ub_mem[10'(10'h3FF + k)], orig[k]);
    end

    // Zero-length tile
    run_tile(10'h000, 10'h000, 10'd0, 5'd0, 1'b0, 0, 1'b0);
    chk("z_done", t_done - s_cyc, 2);
    chk("z_busy_rise", t_bh - s_cyc, 1);
    chk("z_busy_fall", t_bl - s_cyc, 2);
    chk("z_npop", n_pop, 0);
    chk("z_nrd_nwr", n_rd + n_wr, 0);

    // Second start while busy is ignored
    ub_mem[10'h040] = 64'h1111_2222_3333_4444; ub_mem[10'h041] = 64'h5555_6666_7777_0808;
    run_tile(10'h040, 10'h140, 10'd2, 5'd0, 1'b0, 0, 1'b1);
    chk("s2_ndone", n_done, 1);
    chk("s2_done", t_done - s_cyc, 23);
    chk("s2_nwr", n_wr, 2);
    chk("s2_wa0", wr_q.size() > 0 ? wr_q[0] : '1, 10'h140);

    // Reset held 3 cycles during STREAM
    clr();
    cfg_in_base = 10'h050; cfg_out_base = 10'h150; cfg_len = 10'd8; cfg_shift = '0; cfg_relu = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      adv(); start = 1'b0;
      rst = (i >= 5 && i <= 7);
      mon();
    end
    chk("rst_streamed", n_rd > 0, 1);
    chk_idle("rst");
    clr();
    for (int i = 0; i < 40; i++) begin adv(); mon(); end
    chk("rst_nwr", n_wr, 0);
    chk("rst_ndone", n_done, 0);
    chk("rst_nrd", n_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/tpu_tile_sequencer.md
# tpu_tile_sequencer

Parametrised tile controller for the systolic datapath. A single `start` runs one tile: pop one weight set from the weight FIFO, stream `cfg_len` activation vectors from the unified buffer into the array with per-lane skew, de-skew the array outputs, then requantise them and write them back to the unified buffer. It replaces the fixed-size counter/address/data-setup glue around the systolic array with one FSM-driven block sized by parameters.

## Interface
- `ROWS`, 8: result lanes (PE rows).
- `COLS`, 8: activation lanes (matrix size).
- `DATA_BW`, 8: activation and output element width (signed).
- `PSUM_BW`, 20: partial-sum width (signed).
- `ADDR_W`, 10: unified-buffer address width.
- `ARRAY_LAT`, 9: cycles from lane-0 activation entering the array to lane-0 result leaving it.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: one-cycle tile request.
- `cfg_in_base` in ADDR_W: first activation address.
- `cfg_out_base` in ADDR_W: first result address.
- `cfg_len` in ADDR_W: number of vectors, 0..2^ADDR_W-1.
- `cfg_shift` in 5: arithmetic right shift for requantisation.
- `cfg_relu` in 1: clamp negative results to 0.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle end-of-tile pulse.
- `fifo_empty` in 1: weight FIFO empty.
- `fifo_rd_en` out 1: weight FIFO pop.
- `we_rl` out 1: weight reload pulse to the array.
- `ub_rd_en` out 1: UB read strobe.
- `ub_rd_addr` out ADDR_W: UB read address.
- `ub_rd_data` in COLS*DATA_BW: UB read data, valid 1 cycle after `ub_rd_en`.
- `din_skew` out COLS*DATA_BW: skewed activations to the array.
- `array_result` in ROWS*PSUM_BW: raw array outputs (lane j lags lane 0 by j cycles).
- `ub_wr_en` out 1: UB write strobe.
- `ub_wr_addr` out ADDR_W: UB write address.
- `ub_wr_data` out ROWS*DATA_BW: requantised results.

## Operation
- The FSM states are IDLE, WPOP, WLOAD, STREAM, DRAIN and DONE.
- **IDLE**
  - `start` latches all `cfg_*` inputs.
  - If `cfg_len`=0, go to DONE. Otherwise go to WPOP.
  - `start` outside IDLE is ignored. The latched config is not altered.
- **WPOP**
  - Wait while `fifo_empty`=1.
  - When `fifo_empty`=0, assert `fifo_rd_en` for one cycle and go to WLOAD.
- **WLOAD**
  - Assert `we_rl` for one cycle, since FIFO data is valid the cycle after the pop.
  - Go to STREAM.
- **STREAM**
  - Assert `ub_rd_en` for `cfg_len` consecutive cycles.
  - Addresses are `cfg_in_base`+k, modulo 2^ADDR_W.
  - After the last read, go to DRAIN.
- **DRAIN**
  - Stay until the in-flight valid pipeline is empty and the last write has issued.
  - Then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **Skew:** `din_skew` lane i = `ub_rd_data` lane i delayed i cycles. Lane 0 has zero delay. Register stages reset to 0.
- **De-skew:** `array_result` lane j is delayed ROWS-1-j cycles, which aligns all lanes.
- **Requantise**, per lane, registered:
  - Compute r = psum >>> `cfg_shift` (arithmetic shift).
  - If `cfg_relu` and r<0, r=0.
  - Saturate r to [-2^(DATA_BW-1), 2^(DATA_BW-1)-1].
- **Write-back:** the k-th valid result is written to `cfg_out_base`+k, modulo 2^ADDR_W, in issue order.
- A valid-bit shift register of length 1+ARRAY_LAT+ROWS tracks in-flight vectors. No counter-based guessing is used.

## Timing
- **Reset values:**
  - `busy`, `done`, `fifo_rd_en`, `we_rl`, `ub_rd_en`, `ub_wr_en` = 0.
  - All addresses and data outputs = 0.
  - State = IDLE. Skew, de-skew and valid pipelines are cleared.
- **`busy`:** rises the cycle after an accepted `start`. It falls in the same cycle `done` is asserted.
- **Weight load:** `fifo_rd_en` is asserted in the cycle after `start` (FIFO non-empty). `we_rl` follows in the next cycle. The first `ub_rd_en` follows in the cycle after that.
- **Read-to-write latency:** a read issued in cycle t produces its `ub_wr_en` in cycle t+ARRAY_LAT+ROWS+1.
- **Tile length:** with a non-empty FIFO, `done` occurs at `start`+`cfg_len`+ARRAY_LAT+ROWS+4 cycles.
- **Zero-length tile:** `cfg_len`=0 gives `busy` for 1 cycle and `done` 2 cycles after `start`, with no FIFO pop.
- **Reset mid-tile:**
  - Immediate abort. No further reads or writes.
  - In-flight results are discarded and `done` is not pulsed.
- **Ports:** UB reads and writes use separate ports and may occur in the same cycle.

## Test plan
- **Reset:** reset held 3 cycles during STREAM, then released -> all outputs 0, `busy`=0, and no `ub_wr_en` ever appears for the aborted tile.
- **Identity weights:** ROWS=COLS=8, identity weights, `cfg_len`=4, base 0x010 -> 0x100, shift 0 -> UB[0x100..0x103] equals UB[0x010..0x013], and `done` at cycle `start`+4+ARRAY_LAT+12.
- **FIFO stall:** `fifo_empty` held 5 cycles after `start` -> `fifo_rd_en` delayed exactly 5 cycles, with all later timing shifted by 5.
- **Requantise:** psum 1000 with shift 2 -> 127 (saturated). psum -300 with shift 0 and relu=1 -> 0. psum -300 with relu=0 -> -128.
- **Address wrap:** `cfg_in_base`=0x3FE, `cfg_len`=4 -> reads 0x3FE, 0x3FF, 0x000, 0x001. Writes wrap the same way.
- **Start handling:** `cfg_len`=0 -> `done` 2 cycles after `start`, no `fifo_rd_en`. A second `start` while `busy` -> ignored, exactly one `done`.
